// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter and select sequencer for a shared 8:1 bit mux
module mux8_rr_arbiter #(
    parameter int NREQ     = 8,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            s1,
    output logic            s2,
    output logic            s3,
    output logic            valid,
    output logic [2:0]      owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic              valid_q, valid_d;

    logic [NREQ-1:0]   others;
    logic [2:0]        next_ptr;
    logic [2:0]        pick_idx;
    logic              release_now;

    // Scan from the highest offset down so the entry closest to p is the one that sticks.
    function automatic logic [2:0] pick(input logic [NREQ-1:0] r, input logic [2:0] p);
        logic [2:0] idx;
        pick = p;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                pick = idx;
            end
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        others      = req & ~gnt_q;
        next_ptr    = sel_q + 3'd1;
        pick_idx    = pick(req, ptr_q);
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                release_now = !req[sel_q] || ((hold_q == HOLD_LAST) && (|others));
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (en && (|others)) begin
                        pick_idx = pick(others, next_ptr);
                        sel_d    = pick_idx;
                        gnt_d    = NREQ'(1) << pick_idx;
                        hold_d   = '0;
                    end else begin
                        // Selects keep the last owner so the mux does not toggle while idle.
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign s1    = sel_q[2];
    assign s2    = sel_q[1];
    assign s3    = sel_q[0];
    assign owner = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - scoreboard bench for mux8_rr_arbiter with directed vectors
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       s1, s2, s3;
    logic       valid;
    logic [2:0] owner;

    // Mux data pattern i0..i7 = 1,0,1,0,... and the mux the arbiter steers.
    logic [7:0] ivec;
    logic       y;
    assign ivec = 8'b0101_0101;
    assign y    = ivec[{s1, s2, s3}];

    typedef struct {
        logic [7:0] g;
        logic [2:0] s;
        logic       v;
        logic       y;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks;
    int   errors;

    mux8_rr_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .gnt   (gnt),
        .s1    (s1),
        .s2    (s2),
        .s3    (s3),
        .valid (valid),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic e, input logic [7:0] eg, input logic [2:0] es);
        exp_t t;
        @(negedge clk);
        req = r;
        en  = e;
        t.g = eg;
        t.s = es;
        t.v = |eg;
        t.y = ~es[0];
        sb.push_back(t);
    endtask

    task automatic own(input logic [7:0] r, input logic e, input logic [2:0] o);
        step(r, e, 8'(1) << o, o);
    endtask

    task automatic idle(input logic [7:0] r, input logic e, input logic [2:0] s);
        step(r, e, 8'h00, s);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk("gnt", gnt, cur.g);
            chk("sel", {5'b0, s1, s2, s3}, {5'b0, cur.s});
            chk("owner", {5'b0, owner}, {5'b0, cur.s});
            chk("valid", {7'b0, valid}, {7'b0, cur.v});
            if (cur.v) begin
                chk("y", {7'b0, y}, {7'b0, cur.y});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 8'hFF;
        en     = 1'b1;

        // Reset holds everything at zero even with all requesters active.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_valid", {7'b0, valid}, 8'h00);
        chk("rst_sel", {5'b0, s1, s2, s3}, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Full rotation, 4 cycles per owner, back-to-back, wrapping to 0.
        for (int i = 0; i < 33; i++) begin
            own(8'hFF, 1'b1, 3'((i / 4) % 8));
        end
        idle(8'h00, 1'b1, 3'd0);

        // Sole requester keeps the grant; drop -> idle with selects held.
        repeat (10) own(8'h20, 1'b1, 3'd5);
        idle(8'h00, 1'b1, 3'd5);

        // Wrap 6 -> 7 -> 0 -> 7.
        own(8'h40, 1'b1, 3'd6);
        repeat (4) own(8'h81, 1'b1, 3'd7);
        repeat (4) own(8'h81, 1'b1, 3'd0);
        own(8'h81, 1'b1, 3'd7);
        idle(8'h00, 1'b1, 3'd7);

        // Early release 2 -> 3, with owner 3 getting a fresh 4-cycle tenure.
        repeat (2) own(8'h0C, 1'b1, 3'd2);
        own(8'h08, 1'b1, 3'd3);
        repeat (3) own(8'h0C, 1'b1, 3'd3);
        own(8'h0C, 1'b1, 3'd2);
        idle(8'h00, 1'b1, 3'd2);

        // en=0 blocks new grants; an existing grant runs to timeout then goes idle.
        repeat (3) idle(8'h10, 1'b0, 3'd2);
        own(8'h10, 1'b1, 3'd4);
        repeat (3) own(8'h11, 1'b0, 3'd4);
        repeat (2) idle(8'h11, 1'b0, 3'd4);

        // Async reset mid-grant clears outputs without a clock edge.
        own(8'h10, 1'b1, 3'd4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_gnt", gnt, 8'h00);
        chk("async_valid", {7'b0, valid}, 8'h00);
        chk("async_sel", {5'b0, s1, s2, s3}, 8'h00);
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("sb_drained", 8'(sb.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
